// File: rtl/text_crtc.sv
// text_crtc: character-cell video timing and render-pipeline controller.
// Stage 0 produces the beam position, syncs, blanking and the screen/glyph
// addresses. Flags travel through a PIPE_LAT-deep delay line so they meet the
// glyph pixel and attribute returned by external memory. The final register
// stage decodes the attribute into 4-bit RGB.
// Optional feature: define CURSOR_EN to add the blinking underline cursor
// (cursor_addr/cursor_on ports and a 5-bit frame counter).
module text_crtc #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int ROW_STRIDE = 128,
    parameter int ADDR_W     = 12,
    parameter int PIPE_LAT   = 2,
    localparam int ROW_W     = (CHAR_H > 1) ? $clog2(CHAR_H) : 1,
    localparam int COL_W     = (CHAR_W > 1) ? $clog2(CHAR_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    output logic [ADDR_W-1:0] screen_addr,
    output logic [ROW_W-1:0]  glyph_row,
    output logic [COL_W-1:0]  glyph_col,
    input  logic              glyph_pixel,
    input  logic [7:0]        attr,
    output logic [3:0]        r_o,
    output logic [3:0]        g_o,
    output logic [3:0]        b_o,
    output logic              h_sync_o,
    output logic              v_sync_o,
    output logic              frame_start
`ifdef CURSOR_EN
    ,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic              cursor_on
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare code point so the sync end bound never wraps.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(CHAR_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(CHAR_H - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ROW_STRIDE);

    // Stage 0 state: every register describes the pixel at (h_cnt_reg, v_cnt_reg).
    logic              start_reg;   // first enabled cycle after reset lands on (0,0)
    logic [HW-1:0]     h_cnt_reg;
    logic [VW-1:0]     v_cnt_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [ADDR_W-1:0] char_x_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              active_reg;
    logic              hs_reg;
    logic              vs_reg;
    logic              fs_reg;
    logic              cur_reg;

    logic [HW-1:0]     h_next;
    logic [VW-1:0]     v_next;
    logic              line_adv;
    logic [COL_W-1:0]  col_next;
    logic [ROW_W-1:0]  row_next;
    logic [ADDR_W-1:0] char_x_next;
    logic [ADDR_W-1:0] row_base_next;
    logic [ADDR_W-1:0] addr_next;
    logic              active_next;
    logic              hs_next;
    logic              vs_next;
    logic              fs_next;
    logic              cur_next;

    // Next beam position plus the cell/glyph bookkeeping that follows it.
    always_comb begin
        h_next   = h_cnt_reg;
        v_next   = v_cnt_reg;
        line_adv = 1'b0;
        if (start_reg) begin
            h_next   = '0;
            v_next   = '0;
            line_adv = 1'b1;
        end else if (h_cnt_reg == H_LAST) begin
            h_next   = '0;
            line_adv = 1'b1;
            v_next   = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_next = h_cnt_reg + 1'b1;
        end

        // Column within the glyph and cell index; both parked at 0 outside
        // the visible part of the line so the next line prefetches cell 0.
        if ((h_next >= H_ACT) || (h_next == '0)) begin
            col_next    = '0;
            char_x_next = '0;
        end else if (col_reg == COL_LAST) begin
            col_next    = '0;
            char_x_next = char_x_reg + 1'b1;
        end else begin
            col_next    = col_reg + 1'b1;
            char_x_next = char_x_reg;
        end

        // Glyph row and text-row base address; accumulated by addition only.
        row_next      = row_reg;
        row_base_next = row_base_reg;
        if ((v_next >= V_ACT) || (line_adv && (v_next == '0))) begin
            row_next      = '0;
            row_base_next = '0;
        end else if (line_adv) begin
            if (row_reg == ROW_LAST) begin
                row_next      = '0;
                row_base_next = row_base_reg + STRIDE;
            end else begin
                row_next = row_reg + 1'b1;
            end
        end

        addr_next   = row_base_next + char_x_next;
        active_next = (h_next < H_ACT) && (v_next < V_ACT);
        hs_next     = (h_next >= HS_BEG) && (h_next < HS_END);
        vs_next     = (v_next >= VS_BEG) && (v_next < VS_END);
        fs_next     = (h_next == '0) && (v_next == '0);
    end

`ifdef CURSOR_EN
    localparam logic [ROW_W-1:0] ROW_CUR = ROW_W'(CHAR_H - 2);

    logic [4:0] frame_cnt_reg;
    logic [4:0] frame_cnt_next;

    // Cursor hit test against the next position; blink phase from the frame count.
    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        if (fs_next && !start_reg) begin
            frame_cnt_next = frame_cnt_reg + 5'd1;
        end
        cur_next = cursor_on && (addr_next == cursor_addr) &&
                   (row_next >= ROW_CUR) && !frame_cnt_next[4];
    end

    // Frame counter driving the cursor blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (pix_en) begin
            frame_cnt_reg <= frame_cnt_next;
        end
    end
`else
    assign cur_next = 1'b0;
`endif

    // Stage 0 registers: counters, addresses and per-pixel flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_reg    <= 1'b1;
            h_cnt_reg    <= '0;
            v_cnt_reg    <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            char_x_reg   <= '0;
            row_base_reg <= '0;
            addr_reg     <= '0;
            active_reg   <= 1'b0;
            hs_reg       <= 1'b0;
            vs_reg       <= 1'b0;
            fs_reg       <= 1'b0;
            cur_reg      <= 1'b0;
        end else if (pix_en) begin
            start_reg    <= 1'b0;
            h_cnt_reg    <= h_next;
            v_cnt_reg    <= v_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            char_x_reg   <= char_x_next;
            row_base_reg <= row_base_next;
            addr_reg     <= addr_next;
            active_reg   <= active_next;
            hs_reg       <= hs_next;
            vs_reg       <= vs_next;
            fs_reg       <= fs_next;
            cur_reg      <= cur_next;
        end
    end

    assign screen_addr = addr_reg;
    assign glyph_row   = row_reg;
    assign glyph_col   = col_reg;
    assign frame_start = fs_reg;

    // Flag bundle {cursor, vs, hs, active}; all-zero means blank and inactive.
    logic [3:0] s0_bundle;
    logic [3:0] dly_out;
    assign s0_bundle = {cur_reg, vs_reg, hs_reg, active_reg};

    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_dly
        logic [3:0] stage_reg;
        if (gi == 0) begin : g_first
            // First delay stage takes the stage 0 flags.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else if (pix_en) begin
                    stage_reg <= s0_bundle;
                end
            end
        end else begin : g_rest
            // Later delay stages shift the flags along.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else if (pix_en) begin
                    stage_reg <= g_dly[gi-1].stage_reg;
                end
            end
        end
    end

    assign dly_out = g_dly[PIPE_LAT-1].stage_reg;

    // Foreground nibble when the glyph bit (or the cursor) is set.
    logic [3:0] nib;
    always_comb begin
        nib = (glyph_pixel || dly_out[3]) ? attr[7:4] : attr[3:0];
    end

    // Output register: IRGB decode and sync polarity, blanked outside active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o      <= '0;
            g_o      <= '0;
            b_o      <= '0;
            h_sync_o <= ~H_POL;
            v_sync_o <= ~V_POL;
        end else if (pix_en) begin
            h_sync_o <= dly_out[1] ? H_POL : ~H_POL;
            v_sync_o <= dly_out[2] ? V_POL : ~V_POL;
            if (dly_out[0]) begin
                r_o <= {nib[2], {3{nib[3] & nib[2]}}};
                g_o <= {nib[1], {3{nib[3] & nib[1]}}};
                b_o <= {nib[0], {3{nib[3] & nib[0]}}};
            end else begin
                r_o <= '0;
                g_o <= '0;
                b_o <= '0;
            end
        end
    end

endmodule

// File: doc/text_crtc.md
Name: text_crtc

Overview:
Parametrised character-cell video timing and render-pipeline controller, the successor to the fixed 80x25 text mode.
- Generates H/V counters, syncs and blanking for configurable timings.
- Generates the character-cell address and glyph row/column for external screen/colour RAM and glyph ROM.
- Decodes the returned glyph pixel and IRGB attribute into 4-bit RGB, with sync/blank delay-aligned to the memory latency.
- Sits between the screen/colour RAMs plus glyph ROM and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
H_POL, 0, hsync active level
V_POL, 0, vsync active level
CHAR_W, 8, glyph width in pixels (power of 2 not required)
CHAR_H, 16, glyph height in lines
ROW_STRIDE, 128, address increment per text row
ADDR_W, 12, screen address width
PIPE_LAT, 2, pix_en cycles from screen_addr to valid glyph_pixel/attr inputs (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_en  in  1  pixel-rate enable; all state advances only when 1
screen_addr  out  ADDR_W  screen/colour RAM address
glyph_row  out  $clog2(CHAR_H)  row within glyph
glyph_col  out  $clog2(CHAR_W)  column within glyph
glyph_pixel  in  1  glyph bit, PIPE_LAT after address
attr  in  8  colour attribute: [7:4] fg IRGB, [3:0] bg IRGB
r_o, g_o, b_o  out  4 each  video output
h_sync_o, v_sync_o  out  1  syncs, aligned with RGB
frame_start  out  1  one pix_en-cycle pulse at h=0,v=0 (stage 0)
cursor_addr  in  ADDR_W  cursor cell (CURSOR_EN only)
cursor_on  in  1  cursor enable (CURSOR_EN only)

Behaviour:
- Reset: all counters 0, screen_addr 0, glyph_row/col 0, RGB 0, syncs at inactive level (~POL), frame_start 0, delay lines cleared to blank/inactive.
- Reset mid-frame restarts at h=0,v=0 on the next enabled cycle.
- Counters: h_cnt 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters. v_cnt increments on h wrap, 0..V_TOTAL-1, and wraps to 0.
- Stage 0 (registered):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise on v_cnt.
- Sub-counters: glyph_col counts 0..CHAR_W-1 during active h and is forced to 0 in h blanking. glyph_row counts 0..CHAR_H-1 per active line and is forced to 0 in v blanking.
- Addressing: char_x increments on glyph_col wrap. row_base += ROW_STRIDE on glyph_row wrap. screen_addr = row_base + char_x, truncated to ADDR_W.
- Prefetch: during h blanking char_x = 0; during v blanking row_base = 0. No multiplier is used.
- Alignment: active, hs, vs shift through a PIPE_LAT-deep delay line (advances on pix_en), then one output register. RGB/sync outputs lag stage 0 by PIPE_LAT+1 enabled cycles.
- Colour decode, per channel c (R=bit2, G=bit1, B=bit0 of the selected nibble):
  - out[3] = nibble[c].
  - out[2:0] = 3'b111 if nibble[3] & nibble[c], else 3'b000.
  - Nibble = fg if glyph_pixel, else bg.
  - RGB forced to 0 when delayed active is 0.
- pix_en=0: every register holds, outputs stable.

Optional Feature:
- CURSOR_EN defined:
  - Ports cursor_addr and cursor_on exist. A 5-bit frame counter increments on each frame_start.
  - Stage 0 flags the cell when screen_addr==cursor_addr && glyph_row>=CHAR_H-2 && cursor_on && frame_cnt[4]==0. The flag is delayed with the pipeline.
  - When the flag is set, the pixel is treated as foreground regardless of glyph_pixel.
- CURSOR_EN undefined: no cursor ports and no frame counter; output is identical to the flagless path.

Test Plan:
1. Defaults, pix_en=1, 2 frames -> hsync low for exactly 96 clocks of every 800; vsync low for lines 490-491; 525 lines per frame; frame_start once per 420000 clocks.
2. Stage 0 sweep -> screen_addr 0 at (0,0), 1 at h=8, 79 at h=632; on line 16 screen_addr=128; on line 479 at h=632 screen_addr=29*128+79=3791.
3. glyph_pixel=1, attr=8'hC1 -> RGB=F,0,0 (bright red) appears exactly 3 clocks after the matching address. glyph_pixel=0 -> RGB=0,0,8.
4. pix_en toggling 1/0 -> all outputs identical to scenario 1, stretched 2x; no state change on disabled cycles.
5. rst asserted at h=300,v=200 for one clock -> next enabled cycle h=0,v=0, syncs inactive, RGB 0.
6. CURSOR_EN, cursor_addr=5, cursor_on=1, glyph_pixel=0, attr=8'h70 -> frames 0-15: rows 14-15 of cell 5 output 8,8,8; frames 16-31: output 0,0,0.
